// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: write strobe/data in, FIFO status and
// UART line/status out. The master modport is the producer, slave is the transmitter.
interface uart_tx_fifo_if #(
    parameter int c_DATA_BITS  = 8,
    parameter int c_FIFO_DEPTH = 4
);
    logic                           i_TX_DV;
    logic [c_DATA_BITS-1:0]         i_PARALLEL_DATA;
    logic                           o_READY;
    logic [$clog2(c_FIFO_DEPTH):0]  o_FIFO_COUNT;
    logic                           o_OVERFLOW;
    logic                           o_SERIAL_DATA;
    logic                           o_TX_ACTIVE;
    logic                           o_TX_DONE;

    modport master (
        output i_TX_DV, i_PARALLEL_DATA,
        input  o_READY, o_FIFO_COUNT, o_OVERFLOW, o_SERIAL_DATA, o_TX_ACTIVE, o_TX_DONE
    );

    modport slave (
        input  i_TX_DV, i_PARALLEL_DATA,
        output o_READY, o_FIFO_COUNT, o_OVERFLOW, o_SERIAL_DATA, o_TX_ACTIVE, o_TX_DONE
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO. Words are queued and sent back-to-back as
// start + c_DATA_BITS (LSB first) + optional parity + c_STOP_BITS stop bits.
// Optional parity bit: define UART_TX_PARITY_EN (sense chosen by c_PARITY_ODD).
// Line and status outputs decode the registered state, so an asynchronous reset
// forces the line high immediately.
module uart_tx_fifo #(
    parameter int c_CYCLES_PER_BIT = 217,
    parameter int c_DATA_BITS      = 8,
    parameter int c_STOP_BITS      = 1,
    parameter int c_FIFO_DEPTH     = 4,
    parameter int c_PARITY_ODD     = 0
) (
    input  logic           i_CLK,
    input  logic           i_RESET,
    uart_tx_fifo_if.slave  bus
);

    localparam int LP_PW = $clog2(c_FIFO_DEPTH);
    localparam int LP_CW = $clog2(c_FIFO_DEPTH) + 1;
    localparam int LP_KW = $clog2(c_CYCLES_PER_BIT);
    localparam int LP_BW = $clog2(c_DATA_BITS);

    localparam logic [LP_KW-1:0] LP_K_LAST      = LP_KW'(c_CYCLES_PER_BIT - 1);
    localparam logic [LP_BW-1:0] LP_B_DATA_LAST = LP_BW'(c_DATA_BITS - 1);
    localparam logic [LP_BW-1:0] LP_B_STOP_LAST = LP_BW'(c_STOP_BITS - 1);
    localparam logic [LP_CW-1:0] LP_FULL        = LP_CW'(c_FIFO_DEPTH);
    localparam logic             LP_ODD         = (c_PARITY_ODD != 0);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} t_state;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} t_state;
`endif

    t_state                  r_state;
    t_state                  w_state_next;
    logic [LP_KW-1:0]        r_clk_cnt;
    logic [LP_KW-1:0]        w_clk_cnt_next;
    logic [LP_BW-1:0]        r_bit_cnt;
    logic [LP_BW-1:0]        w_bit_cnt_next;

    logic [c_DATA_BITS-1:0]  r_mem [c_FIFO_DEPTH];
    logic [LP_PW-1:0]        r_wr_ptr;
    logic [LP_PW-1:0]        r_rd_ptr;
    logic [LP_CW-1:0]        r_count;
    logic                    r_overflow;
    logic [c_DATA_BITS-1:0]  r_shift;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_shift;
    logic                    w_bit_end;
    logic                    w_serial;
    logic                    w_done;

`ifdef UART_TX_PARITY_EN
    logic                    r_parity;
`else
    // Parity sense has no effect when no parity bit is sent.
    logic                    w_unused_parity_sense;
    assign w_unused_parity_sense = LP_ODD;
`endif

    // Full is judged on the pre-edge count, so a write while full is dropped
    // even when a pop happens on the same edge.
    assign w_push    = bus.i_TX_DV && (r_count != LP_FULL);
    assign w_bit_end = (r_clk_cnt == LP_K_LAST);

    // Next-state, bit timing, FIFO pop and line level for the current state
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt + 1'b1;
        w_bit_cnt_next = r_bit_cnt;
        w_pop          = 1'b0;
        w_shift        = 1'b0;
        w_done         = 1'b0;
        w_serial       = 1'b1;
        case (r_state)
            IDLE: begin
                w_clk_cnt_next = '0;
                if (r_count != '0) begin
                    w_pop          = 1'b1;
                    w_bit_cnt_next = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                w_serial = 1'b0;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                w_serial = r_shift[0];
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_shift        = 1'b1;
                    if (r_bit_cnt == LP_B_DATA_LAST) begin
                        w_bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        w_state_next   = PARITY;
`else
                        w_state_next   = STOP;
`endif
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_serial = r_parity;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = STOP;
                end
            end
`endif
            STOP: begin
                w_serial = 1'b1;
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (r_bit_cnt == LP_B_STOP_LAST) begin
                        w_done         = 1'b1;
                        w_bit_cnt_next = '0;
                        if (r_count != '0) begin
                            w_pop        = 1'b1;
                            w_state_next = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_cnt_next = '0;
            end
        endcase
    end

    // FSM state and bit/clock counters
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
        end
    end

    // FIFO pointers, occupancy and dropped-write pulse
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.i_TX_DV && (r_count == LP_FULL);
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage; no reset needed since the count gates every read
    always_ff @(posedge i_CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.i_PARALLEL_DATA;
    end

    // Shift register loaded from the FIFO head on pop, shifted after each data bit
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
            r_parity <= (^r_mem[r_rd_ptr]) ^ LP_ODD;
`endif
        end else if (w_shift) begin
            r_shift  <= r_shift >> 1;
        end
    end

    assign bus.o_SERIAL_DATA = w_serial;
    assign bus.o_TX_ACTIVE   = (r_state != IDLE);
    assign bus.o_TX_DONE     = w_done;
    assign bus.o_READY       = (r_count != LP_FULL);
    assign bus.o_FIFO_COUNT  = r_count;
    assign bus.o_OVERFLOW    = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 stop bit at 217 clocks/bit, 2 stop bits
// at 16 clocks/bit) share one stimulus stream. Each has a frame-timeline model
// compared on every falling edge, plus hand-computed literal checks.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    // Hand-computed frame figures for the 217-clock instance and the 2-stop instance
    localparam int LIT_LEN0  = (P == 1) ? 2387 : 2170;
    localparam int LIT_DONE0 = (P == 1) ? 2386 : 2169;
    localparam int LIT_DONE1 = (P == 1) ? 191  : 175;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] din = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int CPB   = (g == 0) ? 217 : 16;
        localparam int NSTOP = g + 1;
        localparam int NB    = 1 + 8 + P + NSTOP;
        localparam int FLEN  = NB * CPB;

        uart_tx_fifo_if #(.c_DATA_BITS(8), .c_FIFO_DEPTH(4)) bus ();
        assign bus.i_TX_DV         = dv;
        assign bus.i_PARALLEL_DATA = din;

        uart_tx_fifo #(
            .c_CYCLES_PER_BIT (CPB),
            .c_DATA_BITS      (8),
            .c_STOP_BITS      (NSTOP),
            .c_FIFO_DEPTH     (4),
            .c_PARITY_ODD     (0)
        ) dut (
            .i_CLK   (clk),
            .i_RESET (rst),
            .bus     (bus)
        );

        logic [7:0] q[$];
        int         t      = -1;
        logic       fr[NB];
        logic       m_ovf  = 1'b0;
        int         n_done = 0;

        // Model: queue of accepted words and position t within the current frame
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                q.delete();
                t     = -1;
                m_ovf = 1'b0;
            end else begin
                int         pre;
                logic       pop;
                logic [7:0] w;
                pre = q.size();
                pop = 1'b0;
                if (t < 0) pop = (pre > 0);
                else if (t == FLEN - 1) begin
                    t   = -1;
                    pop = (pre > 0);
                end else t = t + 1;
                if (pop) begin
                    w = q.pop_front();
                    fr[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fr[1+i] = w[i];
                    if (P == 1) fr[9] = ^w;
                    for (int i = 9 + P; i < NB; i++) fr[i] = 1'b1;
                    t = 0;
                end
                if (dv && pre < 4) q.push_back(din);
                m_ovf = dv && (pre == 4);
            end
        end

        // Compare every output against the model on each falling edge
        always @(negedge clk) begin
            logic e_line;
            e_line = (t < 0) ? 1'b1 : fr[t / CPB];
            chk($sformatf("dut%0d line", g),   bus.o_SERIAL_DATA, e_line);
            chk($sformatf("dut%0d active", g), bus.o_TX_ACTIVE,   (t >= 0));
            chk($sformatf("dut%0d done", g),   bus.o_TX_DONE,     (t == FLEN - 1));
            chk($sformatf("dut%0d count", g),  bus.o_FIFO_COUNT,  q.size());
            chk($sformatf("dut%0d ready", g),  bus.o_READY,       (q.size() < 4));
            chk($sformatf("dut%0d ovf", g),    bus.o_OVERFLOW,    m_ovf);
            if (bus.o_TX_DONE) n_done++;
        end
    end

    int k;
    int nd0;
    int nd1;
    int act_all;
    int lit[11] = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 1, 1};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write1(input logic [7:0] d);
        dv  = 1'b1;
        din = d;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst line",   gen_dut[0].bus.o_SERIAL_DATA, 1);
        chk("rst count",  gen_dut[0].bus.o_FIFO_COUNT,  0);
        chk("rst ready",  gen_dut[0].bus.o_READY,       1);
        chk("rst active", gen_dut[0].bus.o_TX_ACTIVE,   0);
        chk("rst ovf",    gen_dut[0].bus.o_OVERFLOW,    0);
        rst = 1'b0;
        tick(2);

        // Single word 8'hCB: latency, bit sequence, done position
        write1(8'hCB);
        chk("cb count after write", gen_dut[0].bus.o_FIFO_COUNT, 1);
        chk("cb idle before pop",   gen_dut[0].bus.o_TX_ACTIVE,  0);
        tick(1);
        k = 0;
        chk("cb start line",   gen_dut[0].bus.o_SERIAL_DATA, 0);
        chk("cb start active", gen_dut[0].bus.o_TX_ACTIVE,   1);
        for (int b = 0; b < 10 + P; b++) begin
            tick(217 * b + 108 - k);
            k = 217 * b + 108;
            chk($sformatf("cb bit%0d", b), gen_dut[0].bus.o_SERIAL_DATA, lit[b]);
        end
        tick(LIT_DONE0 - k);
        k = LIT_DONE0;
        chk("cb done pulse",  gen_dut[0].bus.o_TX_DONE,   1);
        chk("cb done active", gen_dut[0].bus.o_TX_ACTIVE, 1);
        tick(1);
        chk("cb done clear",   gen_dut[0].bus.o_TX_DONE,   0);
        chk("cb active falls", gen_dut[0].bus.o_TX_ACTIVE, 0);
        tick(20);

        // 8'hFF on the 2-stop instance: done on last cycle of second stop bit
        write1(8'hFF);
        tick(1);
        k = 0;
        tick(LIT_DONE1 - 16);
        chk("stop2 no early done", gen_dut[1].bus.o_TX_DONE, 0);
        tick(16);
        chk("stop2 done pulse", gen_dut[1].bus.o_TX_DONE,     1);
        chk("stop2 line high",  gen_dut[1].bus.o_SERIAL_DATA, 1);
        tick(1);
        chk("stop2 active falls", gen_dut[1].bus.o_TX_ACTIVE, 0);
        tick(LIT_LEN0 + 20);

        // Back-to-back 55, AA, 0F
        nd0 = gen_dut[0].n_done;
        dv = 1'b1; din = 8'h55;
        @(negedge clk);
        din = 8'hAA;
        @(negedge clk);
        k = 0;
        act_all = gen_dut[0].bus.o_TX_ACTIVE;
        din = 8'h0F;
        @(negedge clk);
        dv = 1'b0;
        k = 1;
        act_all = act_all & gen_dut[0].bus.o_TX_ACTIVE;
        while (k < 3 * LIT_LEN0 - 1) begin
            tick(1);
            k++;
            act_all = act_all & gen_dut[0].bus.o_TX_ACTIVE;
        end
        chk("b2b active throughout", act_all, 1);
        tick(1);
        chk("b2b active falls", gen_dut[0].bus.o_TX_ACTIVE, 0);
        chk("b2b done pulses",  gen_dut[0].n_done - nd0,    3);
        tick(20);

        // Overflow at depth 4
        nd0 = gen_dut[0].n_done;
        nd1 = gen_dut[1].n_done;
        write1(8'h01);
        tick(10);
        dv = 1'b1;
        din = 8'h10; @(negedge clk);
        din = 8'h11; @(negedge clk);
        din = 8'h12; @(negedge clk);
        din = 8'h13; @(negedge clk);
        chk("ovf count full", gen_dut[0].bus.o_FIFO_COUNT, 4);
        chk("ovf ready low",  gen_dut[0].bus.o_READY,      0);
        din = 8'h14; @(negedge clk);
        dv = 1'b0;
        chk("ovf pulse",      gen_dut[0].bus.o_OVERFLOW,   1);
        chk("ovf count held", gen_dut[0].bus.o_FIFO_COUNT, 4);
        tick(1);
        chk("ovf pulse ends", gen_dut[0].bus.o_OVERFLOW, 0);
        tick(5 * LIT_LEN0 + 50);
        chk("ovf frames dut0", gen_dut[0].n_done - nd0, 5);
        chk("ovf frames dut1", gen_dut[1].n_done - nd1, 5);
        chk("ovf drained",     gen_dut[0].bus.o_FIFO_COUNT, 0);

        // Reset during data bit 3 of 8'hCB with two words queued
        dv = 1'b1; din = 8'hCB;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        k = 0;
        din = 8'h33;
        @(negedge clk);
        dv = 1'b0;
        k = 1;
        tick(900 - k);
        k = 900;
        chk("mid queued", gen_dut[0].bus.o_FIFO_COUNT, 2);
        nd0 = gen_dut[0].n_done;
        #2 rst = 1'b1;
        #1;
        chk("mid rst line",   gen_dut[0].bus.o_SERIAL_DATA, 1);
        chk("mid rst count",  gen_dut[0].bus.o_FIFO_COUNT,  0);
        chk("mid rst active", gen_dut[0].bus.o_TX_ACTIVE,   0);
        chk("mid rst done",   gen_dut[0].bus.o_TX_DONE,     0);
        @(negedge clk);
        tick(3);
        rst = 1'b0;
        tick(300);
        chk("post rst idle line",   gen_dut[0].bus.o_SERIAL_DATA, 1);
        chk("post rst idle active", gen_dut[0].bus.o_TX_ACTIVE,   0);
        chk("post rst no done",     gen_dut[0].n_done - nd0,      0);
        write1(8'hA5);
        tick(LIT_LEN0 + 10);
        chk("a5 one frame", gen_dut[0].n_done - nd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. Accepts words into an internal FIFO and serialises them back-to-back as UART frames: start bit, c_DATA_BITS data bits LSB first, optional parity bit, then c_STOP_BITS stop bits. It sits between game-controller logic and the serial pin. Producers can burst several words without waiting for o_TX_DONE on each one.

Parameters:
c_CYCLES_PER_BIT, 217, clocks per bit (25 MHz / 115200); must be >= 2
c_DATA_BITS, 8, data bits per frame; legal range 5..9
c_STOP_BITS, 1, number of stop bits; 1 or 2
c_FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2
c_PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd

Ports:
i_CLK  in  1  system clock; the only clock
i_RESET  in  1  asynchronous, active-high reset
i_TX_DV  in  1  write strobe; samples i_PARALLEL_DATA on the rising edge
i_PARALLEL_DATA  in  c_DATA_BITS  word to transmit
o_READY  out  1  high when the FIFO is not full
o_FIFO_COUNT  out  $clog2(c_FIFO_DEPTH)+1  number of occupied entries
o_OVERFLOW  out  1  one-cycle pulse when a write is dropped
o_SERIAL_DATA  out  1  UART line; idles high
o_TX_ACTIVE  out  1  high from the first start-bit cycle to the last stop-bit cycle
o_TX_DONE  out  1  one-cycle pulse on the last cycle of the last stop bit

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While i_RESET is high:
  - o_SERIAL_DATA=1, o_TX_ACTIVE=0, o_TX_DONE=0, o_OVERFLOW=0, o_FIFO_COUNT=0, o_READY=1.
  - FIFO pointers, bit counter and clock counter are cleared; state is IDLE.
- Reset mid-frame: the frame is abandoned, the line goes high immediately (asynchronously), and no o_TX_DONE is produced.
- FIFO write:
  - A write occurs when i_TX_DV=1 and count < c_FIFO_DEPTH.
  - "Full" is evaluated on the pre-edge count. A write while full is dropped even if a pop happens on the same edge; o_OVERFLOW pulses on the next cycle.
- Simultaneous push and pop when not full: count is unchanged and data order is preserved. Pointers wrap modulo c_FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Every bit state lasts exactly c_CYCLES_PER_BIT clocks, timed by the clock counter, which is cleared on each state or bit change.
  - IDLE: line high. If count > 0, pop the head word into the shift register and go to START.
  - START: line 0.
  - DATA: line = shift register LSB. Shift right after each bit. After c_DATA_BITS bits, go to PARITY (if compiled in) or STOP.
  - PARITY: line = parity bit.
  - STOP: line 1 for c_STOP_BITS bit periods. On the final cycle, pulse o_TX_DONE. Then, if count > 0, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Latency, empty FIFO in IDLE: DV is sampled at edge N, count becomes 1 after edge N, the pop occurs at edge N+1, and the start bit is on the line after edge N+1.
- o_TX_ACTIVE stays continuously high across back-to-back frames.
- Frame length: 1 + c_DATA_BITS + P + c_STOP_BITS bit periods, where P = 1 if parity is compiled in, else 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted after the data bits. The parity bit is the XOR of the data bits, XOR c_PARITY_ODD.
- Undefined: no PARITY state exists and c_PARITY_ODD is ignored. Frame = start + data + stop.

Test Plan:
- Defaults, no parity. Stimulus: write 8'hCB. Response: start bit after edge N+1; line sequence 0,1,1,0,1,0,0,1,1,1, each bit 217 clocks; o_TX_DONE pulses at 2170 clocks after the start edge; o_TX_ACTIVE falls on the next cycle.
- UART_TX_PARITY_EN, c_PARITY_ODD=0. Stimulus: write 8'hCB (five ones). Response: parity bit = 1, frame is 11 bits. With c_PARITY_ODD=1: parity bit = 0.
- Back-to-back. Stimulus: write 8'h55, 8'hAA, 8'h0F on consecutive cycles. Response: three contiguous frames, 6510 clocks with no idle gap; o_TX_ACTIVE high throughout; three o_TX_DONE pulses; bytes in order.
- Overflow, depth 4. Stimulus: write 8'h01, wait 10 clocks, then write 8'h10 through 8'h14 on five consecutive cycles. Response:
  - o_FIFO_COUNT reaches 4 and o_READY goes low.
  - 8'h14 is dropped and o_OVERFLOW pulses once.
  - Exactly five frames are sent: 01, 10, 11, 12, 13.
- c_STOP_BITS=2. Stimulus: write 8'hFF. Response: frame is 11 bit periods; o_TX_DONE pulses on the last cycle of the second stop bit.
- Reset mid-frame. Stimulus: assert i_RESET during data bit 3 of 8'hCB, with two more words queued. Response:
  - Line goes high immediately; o_FIFO_COUNT=0; no o_TX_DONE.
  - After release the line stays idle.
  - A new write of 8'hA5 transmits correctly.
